truth_table_capture: RTL and testbench
======================================

Name: truth_table_capture

Overview:
Sequential truth-table capture engine, the measuring end of the combinational-function flow. Drives the 4-bit input row {w,x,y,z} through all 16 combinations and samples NUM_FUNCS function outputs per row after a settle interval. Builds one 16-bit minterm mask per function, then streams the masks out over a valid/ready handshake. Sits beside any 4-input/NUM_FUNCS-output combinational block and replaces the hand-run sweep-and-print bench with a synthesizable, checkable capture.

Parameters:
NUM_FUNCS, 10, number of function outputs captured (1..16)
SETTLE_CYCLES, 5, clock cycles between driving a row and sampling f_in (>=1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset
start  input  1  begin a sweep; sampled only in IDLE
w  output  1  input row bit 3 (MSB)
x  output  1  input row bit 2
y  output  1  input row bit 1
z  output  1  input row bit 0 (LSB)
f_in  input  NUM_FUNCS  function outputs from the block under test; bit k = function k
busy  output  1  high from start acceptance until the last mask is accepted
done  output  1  one-cycle pulse after the final mask handshake
out_valid  output  1  mask record available
out_ready  input  1  consumer accepts record
out_idx  output  4  function index of current record
out_mask  output  16  bit r = f_k value at row r, where r = {w,x,y,z}
out_ones  output  5  popcount of out_mask (0..16)

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset: state=IDLE; w,x,y,z=0; busy=0; done=0; out_valid=0; out_idx=0; out_mask=0; out_ones=0; row counter, settle counter, and all mask storage=0. Assertion mid-sweep or mid-dump aborts immediately. No partial results survive.
- States: IDLE, SETTLE, DUMP, DONE.
- IDLE: on the edge with start=1 (edge E0), row=0, {w,x,y,z}=0, settle counter=SETTLE_CYCLES-1, busy=1, go to SETTLE. Otherwise hold.
- SETTLE: the counter decrements each edge. On the edge where the counter is 0:
  - Write mask[k][row]=f_in[k] for all k.
  - If row<15: row++, drive the new row, reload the counter, stay in SETTLE.
  - If row==15: go to DUMP with out_idx=0 and out_valid=1.
- Timing: row r is sampled at edge E0+(r+1)*SETTLE_CYCLES. {w,x,y,z} are registered and change only at those edges (and at E0). f_in is sampled exactly once per row. The first out_valid is high after edge E0+16*SETTLE_CYCLES.
- DUMP:
  - out_mask=mask[out_idx] and out_ones=popcount(mask[out_idx]), both registered or stable while out_valid=1.
  - out_valid/out_idx/out_mask/out_ones do not change until out_valid&out_ready.
  - On a handshake with out_idx<NUM_FUNCS-1: out_idx++, out_valid stays 1 (back-to-back transfers allowed, one per cycle).
  - On a handshake with out_idx==NUM_FUNCS-1: out_valid=0, go to DONE.
  - {w,x,y,z} hold 4'b1111 throughout DUMP.
- DONE: done=1 for exactly one cycle, busy=0, and all outputs return to IDLE values except the masks, which are retained until the next start. Next state is IDLE.
- start while busy is ignored (no restart, no queueing). start held high across DONE→IDLE begins a new sweep on the first IDLE edge. The new sweep fully overwrites every mask.
- out_ready is ignored when out_valid=0.
- NUM_FUNCS<16: out_idx never exceeds NUM_FUNCS-1.
- Widths: row 4 bits, no wrap beyond 15. out_ones is 5 bits so 16 is representable.

Test Plan:
- DUT = the team's 4-input/10-output function block (f0=y, f2=xor-parity style, f3=x|w, f6=~w|xyz, f9 five-minterm). Start, out_ready=1 → records idx0 mask 0xCCCC ones 8; idx2 0x6969 ones 8; idx3 0xFFF0 ones 12; idx6 0x80FF ones 9; idx9 0x9209 ones 5. done pulses once after idx9.
- Timing, SETTLE_CYCLES=5: start at edge E0 → {w,x,y,z} step 0,1,…,15 every 5 cycles; first out_valid after edge E0+80. f_in forced to garbage except in the sample cycle → masks still correct.
- Backpressure: out_ready toggles 1,0,0,1,… → each record is held stable while stalled. Exactly 10 handshakes with idx 0..9 in order, no duplicates or drops.
- start pulsed during SETTLE and during DUMP → ignored; busy stays 1; results match the single-sweep run.
- rst asserted asynchronously at row 7 → outputs zero immediately, without waiting for a clock edge. A new start after release yields full correct masks with no stale bits.
- f_in tied to all-ones, then all-zeros → every mask 0xFFFF ones 16, then 0x0000 ones 0.

Source files
------------

// File: rtl/truth_table_capture.sv
// Truth-table capture engine: sweeps {w,x,y,z} through all 16 rows, samples
// NUM_FUNCS outputs per row after a settle delay, then streams one minterm mask per function.
module truth_table_capture #(
    parameter int NUM_FUNCS     = 10,
    parameter int SETTLE_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 w,
    output logic                 x,
    output logic                 y,
    output logic                 z,
    input  logic [NUM_FUNCS-1:0] f_in,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_idx,
    output logic [15:0]          out_mask,
    output logic [4:0]           out_ones
);

    localparam int              CW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      LAST_IDX      = 4'(NUM_FUNCS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DUMP, DONE} state_t;

    state_t        state;
    logic [3:0]    row;
    logic [CW-1:0] cnt;
    // Sized for the full 4-bit index; entries at or above NUM_FUNCS stay zero.
    logic [15:0]   masks [16];

    logic [15:0]   first_mask;
    logic [3:0]    next_idx;
    logic [15:0]   next_mask;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n += 5'(v[i]);
        return n;
    endfunction

    assign {w, x, y, z} = row;

    // Record 0 must include row 15, which is written on the same edge it is presented.
    assign first_mask = {f_in[0], masks[0][14:0]};
    assign next_idx   = out_idx + 4'd1;
    assign next_mask  = masks[next_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_mask  <= '0;
            out_ones  <= '0;
            // NOTE: the mask store is reset explicitly so an aborted sweep
            // can never leak stale bits into a later result.
            for (int k = 0; k < 16; k++) masks[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row   <= '0;
                        cnt   <= SETTLE_RELOAD;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        for (int k = 0; k < NUM_FUNCS; k++) masks[k][row] <= f_in[k];
                        if (row != 4'hF) begin
                            row <= row + 4'd1;
                            cnt <= SETTLE_RELOAD;
                        end else begin
                            out_idx   <= '0;
                            out_valid <= 1'b1;
                            out_mask  <= first_mask;
                            out_ones  <= popcount(first_mask);
                            state     <= DUMP;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                DUMP: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            out_mask  <= '0;
                            out_ones  <= '0;
                            row       <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_idx  <= next_idx;
                            out_mask <= next_mask;
                            out_ones <= popcount(next_mask);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: drives a 10-function reference block,
// checks sweep timing, backpressure, ignored starts, async abort and constant inputs.
module tb_truth_table_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        w, x, y, z;
    logic [9:0]  f_in;
    logic        busy, done, out_valid, out_ready;
    logic [3:0]  out_idx;
    logic [15:0] out_mask;
    logic [4:0]  out_ones;

    int          vectors     = 0;
    int          miscompares = 0;
    int          t           = 0;
    int          f_mode      = 0;   // 0: function block, 1: all ones, 2: all zeros
    logic        garbage     = 1'b0;
    logic [9:0]  rnd         = '0;
    logic [9:0]  f_func;
    logic [15:0] exp_mask [10];
    logic [4:0]  exp_ones [10];

    truth_table_capture #(.NUM_FUNCS(10), .SETTLE_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .w(w), .x(x), .y(y), .z(z),
        .f_in(f_in), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_mask(out_mask), .out_ones(out_ones)
    );

    always #5 clk = ~clk;

    // Reference 4-input / 10-output combinational block.
    always_comb begin
        f_func    = '0;
        f_func[0] = y;
        f_func[1] = z;
        f_func[2] = ~(x ^ y ^ z);
        f_func[3] = x | w;
        f_func[4] = w & x & y & z;
        f_func[5] = ~(w | x | y | z);
        f_func[6] = ~w | (x & y & z);
        f_func[7] = w ^ z;
        f_func[8] = w;
        f_func[9] = (~w & ~x & ~y & ~z) | (~w & ~x & y & z) | (w & ~x & ~y & z)
                  | (w & x & ~y & ~z) | (w & x & y & z);
    end

    // In garbage mode f_in is only meaningful in the cycle before each sample edge.
    always_comb begin
        f_in = f_func;
        case (f_mode)
            1:       f_in = '1;
            2:       f_in = '0;
            default: f_in = (garbage && (t % 5) != 4) ? rnd : f_func;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        t++;
        rnd = 10'($urandom);
    endtask

    task automatic set_expect_func();
        exp_mask = '{16'hCCCC, 16'hAAAA, 16'h6969, 16'hFFF0, 16'h8000,
                     16'h0001, 16'h80FF, 16'h55AA, 16'hFF00, 16'h9209};
        exp_ones = '{5'd8, 5'd8, 5'd8, 5'd12, 5'd1, 5'd1, 5'd9, 5'd8, 5'd8, 5'd5};
    endtask

    task automatic set_expect_const(input logic [15:0] m, input logic [4:0] n);
        for (int k = 0; k < 10; k++) begin
            exp_mask[k] = m;
            exp_ones[k] = n;
        end
    endtask

    // Starts a sweep and runs to the first out_valid cycle (negedge after E0+80).
    task automatic run_sweep(input bit timing, input int pulse_at);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t     = 0;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i <= 80; i++) begin
            tick();
            start = (i == pulse_at);
            if (timing && (i == 4 || i == 5 || i == 79))
                check($sformatf("row_at_t%0d", i), 32'({w, x, y, z}), 32'(i / 5));
            if (timing && i == 79) check("valid_before_80", 32'(out_valid), 32'd0);
            if (pulse_at > 0 && i == pulse_at + 5) begin
                check("row_after_ignored_start", 32'({w, x, y, z}), 32'(i / 5));
                check("busy_after_ignored_start", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_idx", 32'(out_idx), 32'd0);
        check("row_in_dump", 32'({w, x, y, z}), 32'hF);
    endtask

    // Accepts all ten records; stall_mode gives ready pattern 1,0,0,1,0,0,...
    task automatic drain(input bit stall_mode);
        int          n   = 0;
        int          cyc = 0;
        logic        pv  = 1'b0;
        logic        pr  = 1'b0;
        logic [24:0] prec = '0;
        while (n < 10 && cyc < 200) begin
            out_ready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
            if (pv && !pr)
                check($sformatf("hold_rec%0d", n),
                      32'({out_valid, out_idx, out_mask, out_ones}), 32'({1'b1, prec[24:0]}) | 32'(26'h0));
            if (out_valid && out_ready) begin
                check($sformatf("idx_rec%0d", n), 32'(out_idx), 32'(n));
                check($sformatf("mask_rec%0d", n), 32'(out_mask), 32'(exp_mask[n]));
                check($sformatf("ones_rec%0d", n), 32'(out_ones), 32'(exp_ones[n]));
                n++;
            end
            pv   = out_valid;
            pr   = out_ready;
            prec = {out_idx, out_mask, out_ones};
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (n < 10) check("drain_timeout", 32'(n), 32'd10);
        check("done_pulse", 32'({done, busy, out_valid}), 32'b100);
        check("done_clears_outputs", 32'({out_idx, out_mask, out_ones, w, x, y, z}), 32'd0);
        tick();
        check("done_one_cycle", 32'({done, busy}), 32'b00);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({busy, done, out_valid}), 32'd0);
        check("rst_row", 32'({w, x, y, z}), 32'd0);
        check("rst_record", 32'({out_idx, out_mask, out_ones}), 32'd0);
        rst = 1'b0;
        tick();

        // Sweep 1: garbage f_in outside sample cycles, full timing checks.
        garbage = 1'b1;
        set_expect_func();
        run_sweep(1'b1, 0);
        drain(1'b0);
        garbage = 1'b0;
        tick();

        // Sweep 2: start pulses during SETTLE and DUMP, stalled consumer.
        run_sweep(1'b0, 20);
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("dump_ignores_start", 32'({busy, out_valid, out_idx}), 32'({1'b1, 1'b1, 4'd0}));
        drain(1'b1);
        tick();

        // Sweep 3: asynchronous abort at row 7.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t     = 0;
        start = 1'b0;
        repeat (35) tick();
        check("row7_before_abort", 32'({w, x, y, z}), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("abort_ctrl", 32'({busy, done, out_valid}), 32'd0);
        check("abort_row", 32'({w, x, y, z}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_after_abort", 32'({busy, w, x, y, z}), 32'd0);

        // Sweep 4: clean run after abort.
        run_sweep(1'b0, 0);
        drain(1'b0);

        // Sweeps 5 and 6: constant inputs, each fully overwriting the last.
        f_mode = 1;
        set_expect_const(16'hFFFF, 5'd16);
        run_sweep(1'b0, 0);
        drain(1'b0);
        f_mode = 2;
        set_expect_const(16'h0000, 5'd0);
        run_sweep(1'b0, 0);
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
